// File: rtl/motor_bridge_pkg.sv
// Shared types and widths for the H-bridge motor driver.
// State encodings are visible on the driver's state output, so keep them stable.
package motor_bridge_pkg;

  localparam int STATE_W    = 3;
  localparam int DEAD_CNT_W = 8;
  localparam int GAP_CNT_W  = 10;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_FWD   = 3'd1,
    ST_REV   = 3'd2,
    ST_GAP   = 3'd3,
    ST_BRAKE = 3'd4,
    ST_FAULT = 3'd5
  } bridge_state_e;

endpackage

// File: rtl/motor_bridge_if.sv
// Control and gate-drive bundle between the motor-control register/PWM source and the bridge driver.
// Optional overcurrent signals exist only when BRIDGE_FAULT_EN is defined.
interface motor_bridge_if;
  import motor_bridge_pkg::*;

  logic               pwm_in;
  logic               enable;
  logic               dir;
  logic               brake;
`ifdef BRIDGE_FAULT_EN
  logic               fault;
  logic               fault_clr;
`endif
  logic               ha;
  logic               la;
  logic               hb;
  logic               lb;
  logic [STATE_W-1:0] state;
  logic               busy;

`ifdef BRIDGE_FAULT_EN
  modport master (output pwm_in, enable, dir, brake, fault, fault_clr,
                  input  ha, la, hb, lb, state, busy);
  modport slave  (input  pwm_in, enable, dir, brake, fault, fault_clr,
                  output ha, la, hb, lb, state, busy);
`else
  modport master (output pwm_in, enable, dir, brake,
                  input  ha, la, hb, lb, state, busy);
  modport slave  (input  pwm_in, enable, dir, brake,
                  output ha, la, hb, lb, state, busy);
`endif

endinterface

// File: rtl/motor_bridge_deadtime_leg.sv
// One half-bridge leg: complementary hi/lo drive from a PWM bit with dead time.
// A gate only turns on after the PWM has been steady for DEAD_CYCLES cycles while enabled.
module deadtime_leg
  import motor_bridge_pkg::*;
#(
  parameter int DEAD_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic pwm,
  output logic hi,
  output logic lo
);

  localparam logic [DEAD_CNT_W-1:0] DEAD_LIM = DEAD_CNT_W'(DEAD_CYCLES - 1);
  localparam logic [DEAD_CNT_W-1:0] CNT_MAX  = '1;

  logic [DEAD_CNT_W-1:0] cnt_q, cnt_d;
  logic                  last_q, last_d;
  logic                  en_q, en_d;
  logic                  hi_q, hi_d;
  logic                  lo_q, lo_d;

  // First enabled cycle and every PWM change restart the dead interval with both gates off.
  always_comb begin
    cnt_d  = '0;
    hi_d   = 1'b0;
    lo_d   = 1'b0;
    last_d = pwm;
    en_d   = en;
    if (en && en_q && (pwm == last_q)) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      if (cnt_q >= DEAD_LIM) begin
        hi_d = pwm;
        lo_d = ~pwm;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      last_q <= 1'b0;
      en_q   <= 1'b0;
      hi_q   <= 1'b0;
      lo_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
      en_q   <= en_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/motor_bridge_driver.sv
// H-bridge gate driver: direction/brake FSM with coast gap plus two dead-time legs.
// Define BRIDGE_FAULT_EN to add the latched overcurrent FAULT state and its fault/fault_clr inputs.
module motor_bridge_driver
  import motor_bridge_pkg::*;
#(
  parameter int DEAD_CYCLES    = 8,
  parameter int DIR_GAP_CYCLES = 64
) (
  input logic           clk,
  input logic           rst_n,
  motor_bridge_if.slave bus
);

  localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(DIR_GAP_CYCLES - 1);

  bridge_state_e        state_q, state_d;
  logic [GAP_CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic                 pwm_q, pwm_d;
  logic                 la_s_q, la_s_d;
  logic                 lb_s_q, lb_s_d;
  logic                 leg_a_en, leg_b_en;
  logic                 a_hi, a_lo, b_hi, b_lo;

  always_comb begin
    state_d = state_q;
    pwm_d   = bus.pwm_in;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.brake)       state_d = ST_BRAKE;
        else if (bus.enable) state_d = bus.dir ? ST_REV : ST_FWD;
      end
      ST_FWD: begin
        if (bus.brake || bus.dir) state_d = ST_GAP;
        else if (!bus.enable)     state_d = ST_IDLE;
      end
      ST_REV: begin
        if (bus.brake || !bus.dir) state_d = ST_GAP;
        else if (!bus.enable)      state_d = ST_IDLE;
      end
      ST_GAP: begin
        // Destination is decided from the inputs present when the gap expires.
        if (gap_cnt_q == GAP_LAST) begin
          if (bus.brake)       state_d = ST_BRAKE;
          else if (bus.enable) state_d = bus.dir ? ST_REV : ST_FWD;
          else                 state_d = ST_IDLE;
        end
      end
      ST_BRAKE: begin
        if (!bus.brake) state_d = ST_GAP;
      end
`ifdef BRIDGE_FAULT_EN
      ST_FAULT: begin
        if (bus.fault_clr) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
`ifdef BRIDGE_FAULT_EN
    if (bus.fault) state_d = ST_FAULT;
`endif

    gap_cnt_d = ((state_q == ST_GAP) && (state_d == ST_GAP)) ? gap_cnt_q + 1'b1 : '0;

    // Legs and static low sides follow the next state so gates change together with state.
    leg_a_en = (state_d == ST_FWD);
    leg_b_en = (state_d == ST_REV);
    la_s_d   = (state_d == ST_REV) || (state_d == ST_BRAKE);
    lb_s_d   = (state_d == ST_FWD) || (state_d == ST_BRAKE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      gap_cnt_q <= '0;
      pwm_q     <= 1'b0;
      la_s_q    <= 1'b0;
      lb_s_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      pwm_q     <= pwm_d;
      la_s_q    <= la_s_d;
      lb_s_q    <= lb_s_d;
    end
  end

  deadtime_leg #(.DEAD_CYCLES(DEAD_CYCLES)) u_leg_a (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (leg_a_en),
    .pwm   (pwm_q),
    .hi    (a_hi),
    .lo    (a_lo)
  );

  deadtime_leg #(.DEAD_CYCLES(DEAD_CYCLES)) u_leg_b (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (leg_b_en),
    .pwm   (pwm_q),
    .hi    (b_hi),
    .lo    (b_lo)
  );

  // A leg's switching outputs and its static low side are never active in the same state.
  assign bus.ha    = a_hi;
  assign bus.la    = a_lo | la_s_q;
  assign bus.hb    = b_hi;
  assign bus.lb    = b_lo | lb_s_q;
  assign bus.state = state_q;
  assign bus.busy  = (state_q == ST_GAP)
                   | ((state_q == ST_FWD) & ~a_hi & ~a_lo)
                   | ((state_q == ST_REV) & ~b_hi & ~b_lo);

endmodule

// File: doc/motor_bridge_driver.md
# motor_bridge_driver

Converts one PWM channel from the `peripheral_pwm` block into four H-bridge gate signals for a vacuum drive motor. It inserts dead time on the switching leg and enforces a coast gap when direction reverses. It also provides a brake mode, and it guarantees that no leg ever has its high and low side on together. Three instances sit directly downstream of `peripheral_pwm`, one per `pwm[n]` bit. `dir`, `enable` and `brake` come from a motor-control register.

## Interface
- `DEAD_CYCLES`, default 8: dead time in clk cycles, legal range 1..255.
- `DIR_GAP_CYCLES`, default 64: coast time on direction change or brake entry/exit, legal range 1..1023.
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `clk` in 1: system clock; all state changes on posedge.
- `rst_n` in 1: asynchronous active-low reset.
- `pwm_in` in 1: PWM bit from `peripheral_pwm`, same clock domain.
- `enable` in 1: drive enable.
- `dir` in 1: 0 = forward (leg A switches), 1 = reverse (leg B switches).
- `brake` in 1: request low-side brake.
- `fault` in 1: overcurrent input; present only with `BRIDGE_FAULT_EN`.
- `fault_clr` in 1: clears the latched fault; present only with `BRIDGE_FAULT_EN`.
- `ha`, `la`, `hb`, `lb` out 1 each: high/low gate drives for legs A and B, registered.
- `state` out 3: current FSM state encoding.
- `busy` out 1: high while in GAP or a dead-time interval.

## Operation
- FSM states: IDLE, FWD, REV, GAP, BRAKE, FAULT (FAULT only with the macro).
- Priority, highest first: FAULT > brake > enable/dir.
- IDLE: all gates 0.
  - `brake` -> BRAKE.
  - `enable` -> FWD if `dir`=0, REV if `dir`=1.
- FWD:
  - `hb`=0 and `lb`=1 (leg B low side on).
  - Leg A is complementary to PWM with dead time: `ha` follows PWM, `la` follows ~PWM.
  - `brake` or `dir`=1 -> GAP. `enable`=0 -> IDLE.
- REV: mirror of FWD with legs A and B swapped.
- GAP:
  - All gates 0 for exactly `DIR_GAP_CYCLES` cycles.
  - Then: `brake` -> BRAKE, else `enable` -> FWD/REV per `dir` sampled at gap end, else IDLE.
  - The gap counter restarts only on GAP entry; input changes during GAP do not extend it.
- BRAKE: `la`=`lb`=1, `ha`=`hb`=0. When `brake` falls -> GAP.
- Dead-time leg rules:
  - On a PWM rising edge, the low gate drops in the next cycle. The high gate rises after `DEAD_CYCLES` further cycles of PWM steady high.
  - On a falling edge, the mirror applies.
  - A PWM pulse or gap shorter than or equal to `DEAD_CYCLES` is swallowed: both gates stay 0 and the other gate is not re-asserted until PWM has been stable for `DEAD_CYCLES`.
  - The dead counter saturates; it never wraps.
- Any transition out of FWD/REV clears both dead-time legs to 0 in the same cycle.
- Invariants, always: `ha`&`la`=0, `hb`&`lb`=0, and `ha`&`hb`=0.

## Timing
- Reset values: `ha`=`la`=`hb`=`lb`=0, `state`=IDLE, `busy`=0, all counters 0. Asserting `rst_n` mid-operation forces all of these immediately (asynchronously).
- `pwm_in` is registered once. For a rising edge sampled at edge k:
  - the low gate falls at edge k+1;
  - the high gate rises at edge k+1+`DEAD_CYCLES`.
- FSM input-to-gate latency is 1 cycle: the state and gates update at the edge after the input is sampled.
- GAP occupies exactly `DIR_GAP_CYCLES` cycles. The next state's gates appear at the following edge.
- FWD->REV total dead interval = `DIR_GAP_CYCLES`, plus `DEAD_CYCLES` before the new high side turns on.

## Configuration
- Macro: `BRIDGE_FAULT_EN`.
- When defined:
  - Adds the `fault` and `fault_clr` ports and the FAULT state.
  - `fault`=1 in any state forces all gates 0 in the next cycle and latches FAULT.
  - FAULT exits to IDLE only on `fault_clr`=1 while `fault`=0.
  - `fault` takes priority over a simultaneous `fault_clr`.
- When undefined: no fault ports, and the FAULT encoding is unreachable.

## Structure
- Package `motor_bridge_pkg` holds:
  - the state enum (3-bit encodings: IDLE=0, FWD=1, REV=2, GAP=3, BRAKE=4, FAULT=5);
  - the dead counter width (8) and gap counter width (10) constants.
- Sub-module `deadtime_leg`: one half-bridge complementary generator.
  - Ports: clk, rst_n, en, pwm, hi, lo; parameter DEAD_CYCLES.
  - Instantiated twice, once per leg; the top-level FSM muxes `en` and the static low/high patterns.

## Test plan
Bench parameters: `DEAD_CYCLES`=4, `DIR_GAP_CYCLES`=16.
- Reset: hold `rst_n`=0 with random inputs -> all gates 0, `state`=0. Assert `rst_n`=0 mid-PWM -> gates 0 in the same cycle.
- FWD at 50% duty, 20-cycle period:
  - `la` falls 1 cycle after `pwm_in` rises; `ha` rises 5 cycles after `pwm_in` rises; `lb`=1 and `hb`=0 throughout.
  - After a falling edge, `ha` falls 1 cycle later and `la` rises 5 cycles later.
- Narrow pulse: a 3-cycle high pulse -> `ha` never asserts, and `la` stays 0 until 4 stable low cycles have elapsed.
- `dir` toggled 0->1 in FWD -> all gates 0 for exactly 16 cycles, then REV with `hb` switching and `la`=1.
- `brake` asserted during FWD -> 16-cycle GAP, then `la`=`lb`=1. Release -> 16-cycle GAP -> FWD if `enable`=1.
- With `BRIDGE_FAULT_EN`:
  - `fault` pulsed during REV -> gates 0 next cycle and `state`=5, held after `fault` falls.
  - `fault_clr`=1 -> IDLE.
  - `fault` and `fault_clr` asserted together -> stays in FAULT.
- A shoot-through assertion checks all three invariants in every test.
